// File: rtl/sdes_pkg.sv
// S-DES constant tables, permutation helpers and FSM state type, shared by the
// sequential decryptor and the planned sequential encryptor.
package sdes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KEYGEN,
      ROUND_A,
      ROUND_B,
      DONE
   } state_t;

   // Zero-based source indices; index 0 is the MSB of each ascending vector.
   localparam logic [3:0] P10_T [10] = '{4'd2, 4'd4, 4'd1, 4'd6, 4'd3, 4'd9, 4'd0, 4'd8, 4'd7, 4'd5};
   localparam logic [3:0] P8_T  [8]  = '{4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd9, 4'd8};
   localparam logic [1:0] P4_T  [4]  = '{2'd1, 2'd3, 2'd2, 2'd0};
   localparam logic [2:0] IP_T  [8]  = '{3'd1, 3'd5, 3'd2, 3'd0, 3'd3, 3'd7, 3'd4, 3'd6};
   localparam logic [2:0] IPI_T [8]  = '{3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd7, 3'd5};
   localparam logic [1:0] EP_T  [8]  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};

   localparam logic [1:0] S0_T [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                         '{2'd3, 2'd2, 2'd1, 2'd0},
                                         '{2'd0, 2'd2, 2'd1, 2'd3},
                                         '{2'd3, 2'd1, 2'd3, 2'd2}};
   localparam logic [1:0] S1_T [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                         '{2'd2, 2'd0, 2'd1, 2'd3},
                                         '{2'd3, 2'd0, 2'd1, 2'd0},
                                         '{2'd2, 2'd1, 2'd0, 2'd3}};

   // Outputs are built by shifting bits in, avoiding variable bit-selects.
   function automatic logic [0:9] p10(input logic [0:9] x);
      logic [0:9] y;
      y = '0;
      for (int unsigned i = 0; i < 10; i++) y = {y[1:9], x[P10_T[i]]};
      return y;
   endfunction

   function automatic logic [0:7] p8(input logic [0:9] x);
      logic [0:7] y;
      y = '0;
      for (int unsigned i = 0; i < 8; i++) y = {y[1:7], x[P8_T[i]]};
      return y;
   endfunction

   function automatic logic [0:3] p4(input logic [0:3] x);
      logic [0:3] y;
      y = '0;
      for (int unsigned i = 0; i < 4; i++) y = {y[1:3], x[P4_T[i]]};
      return y;
   endfunction

   function automatic logic [0:7] ip(input logic [0:7] x);
      logic [0:7] y;
      y = '0;
      for (int unsigned i = 0; i < 8; i++) y = {y[1:7], x[IP_T[i]]};
      return y;
   endfunction

   function automatic logic [0:7] ip_inv(input logic [0:7] x);
      logic [0:7] y;
      y = '0;
      for (int unsigned i = 0; i < 8; i++) y = {y[1:7], x[IPI_T[i]]};
      return y;
   endfunction

   function automatic logic [0:7] ep(input logic [0:3] x);
      logic [0:7] y;
      y = '0;
      for (int unsigned i = 0; i < 8; i++) y = {y[1:7], x[EP_T[i]]};
      return y;
   endfunction

   // Rotate each 5-bit half of the key left by one.
   function automatic logic [0:9] ls1(input logic [0:9] x);
      return {x[1:4], x[0], x[6:9], x[5]};
   endfunction

endpackage

// File: rtl/sdes_fk.sv
// S-DES round function fk: (L,R) -> (L xor F(R,sk), R). Purely combinational.
module sdes_fk
   import sdes_pkg::*;
(
   input  logic [0:7] din,
   input  logic [0:7] sk,
   output logic [0:7] dout
);

   logic [0:7] e;
   logic [0:1] s0, s1;

   always_comb begin
      e    = ep(din[4:7]) ^ sk;
      // Row from outer bits, column from inner bits of each half.
      s0   = S0_T[{e[0], e[3]}][{e[1], e[2]}];
      s1   = S1_T[{e[4], e[7]}][{e[5], e[6]}];
      dout = {din[0:3] ^ p4({s0, s1}), din[4:7]};
   end

endmodule

// File: rtl/sdes_decrypt_seq.sv
// Sequential S-DES decryptor: keygen, two fk rounds (K2 then K1) through one
// shared fk instance, then a held result with valid/ready handshake.
module sdes_decrypt_seq
   import sdes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:9] key,
   input  logic [0:7] ciphertext,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [0:7] plaintext,
   output logic       out_valid,
   input  logic       out_ready
);

   state_t     state, next_state;
   logic [0:9] key_r, ls_key;
   logic [0:7] ct_r, k1, k2, mid_r;
   logic [0:7] fk_in, fk_key, fk_out;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = KEYGEN;
         KEYGEN:  next_state = ROUND_A;
         ROUND_A: next_state = ROUND_B;
         ROUND_B: next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign ls_key    = ls1(p10(key_r));

   // ROUND_B feeds the nibble-swapped first-round result and uses K1.
   always_comb begin
      fk_in  = ip(ct_r);
      fk_key = k2;
      if (state == ROUND_B) begin
         fk_in  = {mid_r[4:7], mid_r[0:3]};
         fk_key = k1;
      end
   end

   sdes_fk u_fk (
      .din  (fk_in),
      .sk   (fk_key),
      .dout (fk_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_r     <= '0;
         ct_r      <= '0;
         k1        <= '0;
         k2        <= '0;
         mid_r     <= '0;
         plaintext <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  key_r <= key;
                  ct_r  <= ciphertext;
               end
            end
            KEYGEN: begin
               k1 <= p8(ls_key);
               k2 <= p8(ls1(ls1(ls_key)));
            end
            ROUND_A: mid_r     <= fk_out;
            ROUND_B: plaintext <= ip_inv(fk_out);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Bench for sdes_decrypt_seq: directed vectors plus randomized traffic scored
// against an integer-arithmetic S-DES model.
module tb_sdes_decrypt_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:9] key;
   logic [0:7] ciphertext;
   logic       in_valid;
   logic       in_ready;
   logic [0:7] plaintext;
   logic       out_valid;
   logic       out_ready;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int acc_cnt = 0;
   int last_acc = 0;
   bit have_last = 0;
   bit ii_mode = 0;
   bit rt_mode = 0;
   int cur_pt = 0;
   int exp_q[$];

   // One-based S-DES tables, MSB = position 1.
   int m_p10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   int m_p8 [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
   int m_p4 [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
   int m_ip [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
   int m_ipi[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
   int m_ep [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
   int m_s0 [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   int m_s1 [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   sdes_decrypt_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .ciphertext (ciphertext),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int perm(int v, int nin, int t[10], int nout);
      int r = 0;
      for (int i = 0; i < nout; i++) r = (r << 1) | ((v >> (nin - t[i])) & 1);
      return r;
   endfunction

   function automatic int rot5(int x, int n);
      return ((x << n) | (x >> (5 - n))) & 31;
   endfunction

   function automatic int f_box(int r4, int sk);
      int e, l, r, s0, s1;
      e  = perm(r4, 4, m_ep, 8) ^ sk;
      l  = e >> 4;
      r  = e & 15;
      s0 = m_s0[(((l >> 3) & 1) * 2 + (l & 1)) * 4 + ((l >> 1) & 3)];
      s1 = m_s1[(((r >> 3) & 1) * 2 + (r & 1)) * 4 + ((r >> 1) & 3)];
      return perm(s0 * 4 + s1, 4, m_p4, 4);
   endfunction

   function automatic int fk_m(int v, int sk);
      return (((v >> 4) ^ f_box(v & 15, sk)) << 4) | (v & 15);
   endfunction

   function automatic int sdes(int k, int blk, bit encrypt);
      int p, l, r, k1, k2, x;
      p  = perm(k, 10, m_p10, 10);
      l  = p >> 5;
      r  = p & 31;
      k1 = perm((rot5(l, 1) << 5) | rot5(r, 1), 10, m_p8, 8);
      k2 = perm((rot5(l, 3) << 5) | rot5(r, 3), 10, m_p8, 8);
      x  = perm(blk, 8, m_ip, 8);
      x  = fk_m(x, encrypt ? k1 : k2);
      x  = ((x & 15) << 4) | (x >> 4);
      x  = fk_m(x, encrypt ? k2 : k1);
      return perm(x, 8, m_ipi, 8);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int max_cyc);
      int n = 0;
      while (!out_valid && n < max_cyc) begin
         step();
         n++;
      end
      check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   // Scoreboard sampled on the falling edge, where all inputs are settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         have_last = 0;
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(rt_mode ? cur_pt : sdes(int'(key), int'(ciphertext), 1'b0));
            acc_cnt++;
            if (ii_mode && have_last) check_eq("accept_interval", 32'(cyc - last_acc), 32'd5);
            last_acc  = cyc;
            have_last = 1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("spurious_output", 32'd1, 32'd0);
            else                   check_eq("scoreboard", 32'(plaintext), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int keys[32];
      int target;
      int n;
      logic [0:7] held;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      key = '0; ciphertext = '0;
      repeat (2) step();
      rst_n = 1'b1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_plaintext", 32'(plaintext), 32'd0);

      // Known vector, latency and stall behaviour.
      key = 10'b1010000010; ciphertext = 8'b01110111; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("lat_e1_valid", 32'(out_valid), 32'd0);
      check_eq("busy_in_ready", 32'(in_ready), 32'd0);
      step();
      check_eq("k1", 32'(dut.k1), 32'b10100100);
      check_eq("k2", 32'(dut.k2), 32'b01000011);
      check_eq("lat_e2_valid", 32'(out_valid), 32'd0);
      step();
      check_eq("lat_e3_valid", 32'(out_valid), 32'd0);
      step();
      check_eq("lat_e4_valid", 32'(out_valid), 32'd1);
      check_eq("known_plain", 32'(plaintext), 32'b01110010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_valid", 32'(out_valid), 32'd1);
         check_eq("stall_plain", 32'(plaintext), 32'b01110010);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      check_eq("release_valid", 32'(out_valid), 32'd0);
      check_eq("release_in_ready", 32'(in_ready), 32'd1);

      // Inputs changing while busy must not affect the accepted job.
      key = 10'b1010000010; ciphertext = 8'b01110111; in_valid = 1'b1;
      step();
      n = 0;
      while (!out_valid && n < 10) begin
         ciphertext = 8'($urandom);
         key = 10'($urandom);
         step();
         n++;
      end
      check_eq("busy_change_valid", 32'(out_valid), 32'd1);
      check_eq("busy_change_plain", 32'(plaintext), 32'b01110010);
      in_valid = 1'b0;
      step();

      // Back-to-back jobs: one accept every five cycles.
      ii_mode = 1; have_last = 0;
      target = acc_cnt + 40;
      in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (acc_cnt < target && n < 400) begin
         key = 10'($urandom);
         ciphertext = 8'($urandom);
         step();
         n++;
      end
      check_eq("b2b_count", 32'(acc_cnt >= target), 32'd1);
      in_valid = 1'b0;
      repeat (6) step();
      ii_mode = 0;

      // Round trip: encrypt in the model, decrypt in the DUT, random stalls.
      for (int i = 0; i < 32; i++) keys[i] = $urandom_range(0, 1023);
      rt_mode = 1;
      target = acc_cnt + 256;
      n = 0;
      while (acc_cnt < target && n < 6000) begin
         cur_pt     = $urandom_range(0, 255);
         key        = 10'(keys[$urandom_range(0, 31)]);
         ciphertext = 8'(sdes(int'(key), cur_pt, 1'b1));
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = $urandom_range(0, 1) != 0;
         step();
         n++;
      end
      check_eq("rt_count", 32'(acc_cnt >= target), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      rt_mode = 0;
      check_eq("rt_drained", 32'(exp_q.size()), 32'd0);

      // Reset during ROUND_A aborts the job.
      out_ready = 1'b0;
      key = 10'b1010000010; ciphertext = 8'b01110111; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      held = plaintext;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_plaintext", 32'(plaintext), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq("abort_no_stale", 32'(out_valid), 32'd0);
      end
      check_eq("abort_plain_hold", 32'(plaintext), 32'd0);
      if (held == 8'h00) check_eq("pre_abort_plain", 32'(held), 32'(held));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
